// File: rtl/gshare_predictor.sv
// Gshare branch predictor: a PC/GHR-hashed table of N-bit saturating counters, 1-cycle predict, non-speculative GHR.
// Define GSHARE_PREDICTOR_STATS_EN to build the branch and misprediction statistics counters.
module gshare_predictor #(
  parameter int K         = 4,
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int HASH_MODE = 1,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_valid,
  input  logic [K-1:0]  pred_index,
  output logic          pred_out_valid,
  output logic          prediction,
  output logic [M-1:0]  pred_hist,
  input  logic          upd_valid,
  input  logic [K-1:0]  upd_index,
  input  logic [M-1:0]  upd_hist,
  input  logic          upd_taken,
  input  logic          upd_predicted,
  output logic          success,
  output logic [CW-1:0] branch_count,
  output logic [CW-1:0] mispredict_count
);

  localparam int AW    = (HASH_MODE != 0) ? K : K + M;
  localparam int DEPTH = 1 << AW;
  localparam logic [N-1:0] CTR_MAX  = '1;
  localparam logic [N-1:0] CTR_INIT = {1'b0, {(N-1){1'b1}}};

  logic [N-1:0]  pht [DEPTH];
  logic [M-1:0]  ghr;
  logic [M-1:0]  ghr_next;
  logic [AW-1:0] pred_addr;
  logic [AW-1:0] upd_addr;
  logic [N-1:0]  upd_ctr;
  logic [N-1:0]  upd_ctr_next;

  // Address hash: XOR folds the zero-extended history into the index, concatenation widens the table.
  if (HASH_MODE != 0) begin : g_xor
    logic [K-1:0] pred_hist_ext;
    logic [K-1:0] upd_hist_ext;
    always_comb begin
      pred_hist_ext         = '0;
      pred_hist_ext[M-1:0]  = ghr;
      upd_hist_ext          = '0;
      upd_hist_ext[M-1:0]   = upd_hist;
    end
    assign pred_addr = pred_index ^ pred_hist_ext;
    assign upd_addr  = upd_index ^ upd_hist_ext;
  end else begin : g_cat
    assign pred_addr = {pred_index, ghr};
    assign upd_addr  = {upd_index, upd_hist};
  end

  if (M == 1) begin : g_ghr1
    assign ghr_next = upd_taken;
  end else begin : g_ghrn
    assign ghr_next = {ghr[M-2:0], upd_taken};
  end

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    upd_ctr      = pht[upd_addr];
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + N'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - N'(1);
    end
  end

  // NOTE: the table is reset entry by entry because a freshly reset predictor must start weakly
  // not-taken; this is a register file, not a RAM macro. Non-blocking writes here also make a
  // same-cycle read see the pre-update counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
    end else if (upd_valid) begin
      pht[upd_addr] <= upd_ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr            <= '0;
      pred_out_valid <= 1'b0;
      prediction     <= 1'b0;
      pred_hist      <= '0;
      success        <= 1'b0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        prediction <= pht[pred_addr][N-1];
        pred_hist  <= ghr;
      end
      if (upd_valid) begin
        ghr     <= ghr_next;
        success <= (upd_predicted == upd_taken);
      end
    end
  end

`ifdef GSHARE_PREDICTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      if (branch_count != '1) branch_count <= branch_count + CW'(1);
      if ((upd_predicted != upd_taken) && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CW'(1);
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
